frame_fifo: RTL and testbench
=============================

FRAME_FIFO -- requirements
Module: frame_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per beat.
REQ-002 SHALL have parameter ABITS, default 4: address bits, DEPTH = 2**ABITS beats.
REQ-003 SHALL have parameter DROP_ON_FULL, default 1: 1 = discard a packet that overflows; 0 = backpressure when full.
REQ-004 SHALL have port clock, input, 1 bit: the only clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports s_tvalid, s_tready, s_tlast, s_tdrop: 1 bit each (ready is the only output); s_tdrop means "abandon current packet".
REQ-007 SHALL have port s_tdata, input, WIDTH bits: write data.
REQ-008 SHALL have ports m_tvalid (output), m_tready (input), m_tlast (output): 1 bit each, read-side AXI-Stream handshake.
REQ-009 SHALL have port m_tdata, output, WIDTH bits: read data.
REQ-010 SHALL have port level_o, output, ABITS+1 bits: beats stored, committed plus pending.
REQ-011 SHALL have port packets_o, output, ABITS+1 bits: committed packets not yet fully read.
REQ-012 SHALL have ports overflow_o and dropped_o, output, 1 bit each: single-cycle event pulses.

Function
REQ-013 SHALL keep write pointer waddr, commit pointer paddr and read pointer raddr, each ABITS+1 bits wide; all SHALL wrap modulo 2**(ABITS+1).
REQ-014 SHALL run the write FSM in two states, PASS and DISCARD; reset state is PASS.
REQ-015 In PASS, a beat SHALL be accepted on s_tvalid && s_tready; the pair {s_tlast, s_tdata} SHALL be written at waddr and waddr SHALL increment.
REQ-016 Accepting a beat in PASS with s_tlast=1 and s_tdrop=0 SHALL commit the packet: paddr <= waddr+1 on the same edge, and packets_o increments.
REQ-017 Accepting a beat in PASS with s_tdrop=1 SHALL do three things: waddr <= paddr, no commit, and dropped_o=1 for the following cycle.
REQ-018 If the REQ-017 beat also has s_tlast=0, the FSM SHALL enter DISCARD.
REQ-019 Full means level_o == DEPTH.
REQ-020 With DROP_ON_FULL=1, s_tready SHALL be 1 in both states.
REQ-021 With DROP_ON_FULL=1, a valid beat arriving in PASS while full SHALL cause waddr <= paddr, overflow_o pulse and entry to DISCARD; if that beat has s_tlast=1, the FSM stays in PASS.
REQ-022 With DROP_ON_FULL=0, s_tready SHALL be !full.
REQ-023 With DROP_ON_FULL=0, if full and paddr==raddr (one packet larger than DEPTH), the FIFO SHALL apply REQ-021 so it cannot deadlock.
REQ-024 In DISCARD, beats SHALL be accepted and not stored; s_tvalid && s_tlast SHALL return the FSM to PASS.
REQ-025 Read data SHALL be available when raddr != paddr; the SRAM read SHALL be registered into an output stage.
REQ-026 The output stage SHALL fetch on (raddr != paddr) && (!m_tvalid || m_tready); a fetch increments raddr.
REQ-027 Sustained throughput SHALL be one beat per cycle on both ports.
REQ-028 Latency: a last beat accepted in cycle t into an empty FIFO SHALL give m_tvalid=1 in cycle t+2.
REQ-029 Only committed data SHALL ever appear on m_*.
REQ-030 packets_o SHALL decrement on m_tvalid && m_tready && m_tlast; a simultaneous commit and final read SHALL leave packets_o unchanged.
REQ-031 level_o SHALL equal waddr - raddr, registered, and SHALL reflect a rewind on the cycle after it occurs.
REQ-032 A commit and a read in the same cycle at the full boundary SHALL lose no data.

Reset
REQ-033 Assertion of reset SHALL asynchronously clear waddr, paddr, raddr, packets_o, level_o, m_tvalid, overflow_o and dropped_o, and set the FSM to PASS.
REQ-034 During reset, s_tready SHALL be 0.
REQ-035 s_tready SHALL be 1 from the first clock edge after reset release.
REQ-036 Reset asserted mid-packet SHALL discard all contents, pending and committed.
REQ-037 SRAM contents need not be cleared.

Structure
REQ-038 FSM encodings and DEPTH SHALL be module-local localparams; no shared package SHALL be used.
REQ-039 Storage SHALL be one sub-module, sdp_sram: simple dual-port, WIDTH+1 bits by DEPTH, synchronous write, registered read, so it infers block RAM.

Verification
REQ-040 Send a 3-beat packet (0x11, 0x22, 0x33 with last) into an empty FIFO -> m_tvalid in cycle t+2, beats 0x11/0x22/0x33 in order, m_tlast on 0x33, packets_o 1 then 0.
REQ-041 Send 2 beats, then a beat with s_tdrop=1 and last=0, then 2 more beats ending in last -> dropped_o pulses once, nothing output, level_o returns to 0.
REQ-042 With DROP_ON_FULL=1, ABITS=4 and m_tready=0, send a 10-beat packet then a 10-beat packet -> first packet is read intact, overflow_o pulses once, second packet is absent.
REQ-043 With DROP_ON_FULL=0, ABITS=4, send a 20-beat packet -> s_tready stays high as the rule requires, overflow_o pulses, and a following 2-beat packet is delivered.
REQ-044 Stream 100 random-length packets with random m_tready -> output equals input minus dropped packets, and packets_o/level_o match a scoreboard every cycle.
REQ-045 Assert reset mid-packet with 1 packet committed -> all outputs 0 and the next packet is delivered correctly.

Source files
------------

// File: rtl/sdp_sram.sv
// Simple dual-port storage: one synchronous write port and one registered read
// port with a read enable, so the read word holds while the consumer stalls.
module sdp_sram #(
    parameter int DW = 9,
    parameter int AW = 4
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata_q
);

    logic [DW-1:0] mem_q [2**AW];

    // Write port
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port; word is held when re is low
    always_ff @(posedge clock) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/frame_fifo.sv
// Packet FIFO: beats are written speculatively and become visible to the reader
// only when the packet's last beat commits; dropped or overflowing packets rewind.
module frame_fifo #(
    parameter int WIDTH        = 8,
    parameter int ABITS        = 4,
    parameter int DROP_ON_FULL = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    input  logic             s_tdrop,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic [WIDTH-1:0] m_tdata,
    output logic [ABITS:0]   level_o,
    output logic [ABITS:0]   packets_o,
    output logic             overflow_o,
    output logic             dropped_o
);

    localparam int             DEPTH      = 2 ** ABITS;
    localparam logic [ABITS:0] FULL_LEVEL = (ABITS + 1)'(DEPTH);
    localparam logic [ABITS:0] PTR_ONE    = (ABITS + 1)'(1);
    localparam bit             DROP_EN    = (DROP_ON_FULL != 0) ? 1'b1 : 1'b0;

    typedef enum logic [0:0] {
        PASS    = 1'b0,
        DISCARD = 1'b1
    } wr_state_e;

    wr_state_e      state_q, state_d;
    logic [ABITS:0] waddr_q, waddr_d;
    logic [ABITS:0] paddr_q, paddr_d;
    logic [ABITS:0] raddr_q, raddr_d;
    logic [ABITS:0] level_q, level_d;
    logic [ABITS:0] packets_q, packets_d;
    logic           mvalid_q, mvalid_d;
    logic           overflow_q, overflow_d;
    logic           dropped_q, dropped_d;
    logic           ready_en_q;

    logic             full_s;
    logic             accept_s;
    logic             wr_en_s;
    logic             commit_s;
    logic             fetch_s;
    logic             read_last_s;
    logic [WIDTH:0]   rd_word_s;

    // level_q always equals waddr_q - raddr_q, so full is exact, not lagged.
    // A full FIFO holding only the packet being written must still accept
    // beats, otherwise that packet could never finish.
    assign full_s      = (level_q == FULL_LEVEL);
    assign s_tready    = ready_en_q &&
                         (DROP_EN || (state_q == DISCARD) || !full_s || (paddr_q == raddr_q));
    assign accept_s    = s_tvalid && s_tready;
    assign fetch_s     = (raddr_q != paddr_q) && (!mvalid_q || m_tready);
    assign read_last_s = mvalid_q && m_tready && m_tlast;

    // Write-side state machine: store, commit, rewind on drop or overflow
    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        paddr_d    = paddr_q;
        wr_en_s    = 1'b0;
        commit_s   = 1'b0;
        overflow_d = 1'b0;
        dropped_d  = 1'b0;
        case (state_q)
            PASS: begin
                if (accept_s) begin
                    if (full_s) begin
                        waddr_d    = paddr_q;
                        overflow_d = 1'b1;
                        state_d    = s_tlast ? PASS : DISCARD;
                    end else if (s_tdrop) begin
                        wr_en_s   = 1'b1;
                        waddr_d   = paddr_q;
                        dropped_d = 1'b1;
                        state_d   = s_tlast ? PASS : DISCARD;
                    end else begin
                        wr_en_s = 1'b1;
                        waddr_d = waddr_q + PTR_ONE;
                        if (s_tlast) begin
                            paddr_d  = waddr_q + PTR_ONE;
                            commit_s = 1'b1;
                        end else begin
                            paddr_d = paddr_q;
                        end
                    end
                end else begin
                    state_d = PASS;
                end
            end
            DISCARD: begin
                if (s_tvalid && s_tlast) begin
                    state_d = PASS;
                end else begin
                    state_d = DISCARD;
                end
            end
            default: begin
                state_d = PASS;
            end
        endcase
    end

    // Read side, packet count and level bookkeeping
    always_comb begin
        raddr_d   = raddr_q;
        mvalid_d  = mvalid_q;
        packets_d = packets_q;
        if (fetch_s) begin
            raddr_d  = raddr_q + PTR_ONE;
            mvalid_d = 1'b1;
        end else if (m_tready) begin
            mvalid_d = 1'b0;
        end else begin
            mvalid_d = mvalid_q;
        end
        case ({commit_s, read_last_s})
            2'b10:   packets_d = packets_q + PTR_ONE;
            2'b01:   packets_d = packets_q - PTR_ONE;
            default: packets_d = packets_q;
        endcase
        level_d = waddr_d - raddr_d;
    end

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= PASS;
            waddr_q    <= '0;
            paddr_q    <= '0;
            raddr_q    <= '0;
            level_q    <= '0;
            packets_q  <= '0;
            mvalid_q   <= 1'b0;
            overflow_q <= 1'b0;
            dropped_q  <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            waddr_q    <= waddr_d;
            paddr_q    <= paddr_d;
            raddr_q    <= raddr_d;
            level_q    <= level_d;
            packets_q  <= packets_d;
            mvalid_q   <= mvalid_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
            ready_en_q <= 1'b1;
        end
    end

    sdp_sram #(
        .DW (WIDTH + 1),
        .AW (ABITS)
    ) u_sram (
        .clock   (clock),
        .we      (wr_en_s),
        .waddr   (waddr_q[ABITS-1:0]),
        .wdata   ({s_tlast, s_tdata}),
        .re      (fetch_s),
        .raddr   (raddr_q[ABITS-1:0]),
        .rdata_q (rd_word_s)
    );

    assign m_tvalid   = mvalid_q;
    assign m_tdata    = rd_word_s[WIDTH-1:0];
    assign m_tlast    = rd_word_s[WIDTH];
    assign level_o    = level_q;
    assign packets_o  = packets_q;
    assign overflow_o = overflow_q;
    assign dropped_o  = dropped_q;

endmodule

// File: tb/tb_frame_fifo.sv
// Directed and scoreboarded bench for frame_fifo; instance A drops on full,
// instance B applies backpressure.
module tb_frame_fifo;

    logic       clk;
    logic       rst_n;

    logic       sa_v, sa_rdy, sa_l, sa_dr, ma_v, ma_r, ma_l, ovf_a, drp_a;
    logic [7:0] sa_data, ma_data;
    logic [4:0] lvl_a, pk_a;

    logic       sb_v, sb_rdy, sb_l, sb_dr, mb_v, mb_r, mb_l, ovf_b, drp_b;
    logic [7:0] sb_data, mb_data;
    logic [4:0] lvl_b, pk_b;

    int n_tests;
    int n_fail;

    frame_fifo #(.WIDTH(8), .ABITS(4), .DROP_ON_FULL(1)) dut_a (
        .clock(clk), .reset(rst_n),
        .s_tvalid(sa_v), .s_tready(sa_rdy), .s_tlast(sa_l), .s_tdrop(sa_dr), .s_tdata(sa_data),
        .m_tvalid(ma_v), .m_tready(ma_r), .m_tlast(ma_l), .m_tdata(ma_data),
        .level_o(lvl_a), .packets_o(pk_a), .overflow_o(ovf_a), .dropped_o(drp_a)
    );

    frame_fifo #(.WIDTH(8), .ABITS(4), .DROP_ON_FULL(0)) dut_b (
        .clock(clk), .reset(rst_n),
        .s_tvalid(sb_v), .s_tready(sb_rdy), .s_tlast(sb_l), .s_tdrop(sb_dr), .s_tdata(sb_data),
        .m_tvalid(mb_v), .m_tready(mb_r), .m_tlast(mb_l), .m_tdata(mb_data),
        .level_o(lvl_b), .packets_o(pk_b), .overflow_o(ovf_b), .dropped_o(drp_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic l, input logic dr, input logic [7:0] d);
        sa_v = v; sa_l = l; sa_dr = dr; sa_data = d;
        tick();
        sa_v = 1'b0; sa_l = 1'b0; sa_dr = 1'b0;
    endtask

    task automatic drive_b(input logic v, input logic l, input logic dr, input logic [7:0] d);
        sb_v = v; sb_l = l; sb_dr = dr; sb_data = d;
        tick();
        sb_v = 1'b0; sb_l = 1'b0; sb_dr = 1'b0;
    endtask

    // Reference model of instance A for the random run
    logic [8:0] pend_q[$];
    logic [8:0] stor_q[$];
    logic [8:0] mo_b;
    bit         mo_v, m_disc, m_ovf, m_drp;
    int         mo_pk;

    task automatic model_step(input bit sv, input bit sl, input bit sd, input logic [7:0] sdt, input bit mr);
        int lvl;
        bit fetch, rl, commit;
        lvl    = pend_q.size() + stor_q.size();
        fetch  = (stor_q.size() > 0) && (!mo_v || mr);
        rl     = mo_v && mr && mo_b[8];
        commit = 1'b0;
        m_ovf  = 1'b0;
        m_drp  = 1'b0;
        if (fetch) begin
            mo_b = stor_q.pop_front();
            mo_v = 1'b1;
        end else if (mr) begin
            mo_v = 1'b0;
        end
        if (!m_disc && sv) begin
            if (lvl == 16) begin
                pend_q.delete(); m_ovf = 1'b1; m_disc = !sl;
            end else if (sd) begin
                pend_q.delete(); m_drp = 1'b1; m_disc = !sl;
            end else begin
                pend_q.push_back({sl, sdt});
                if (sl) begin
                    foreach (pend_q[i]) stor_q.push_back(pend_q[i]);
                    pend_q.delete();
                    commit = 1'b1;
                end
            end
        end else if (m_disc && sv && sl) begin
            m_disc = 1'b0;
        end
        mo_pk = mo_pk + int'(commit) - int'(rl);
    endtask

    task automatic rcyc(input logic v, input logic l, input logic dr, input logic [7:0] d, input logic mr);
        sa_v = v; sa_l = l; sa_dr = dr; sa_data = d; ma_r = mr;
        check("r_rdy", sa_rdy, 1);
        model_step(v, l, dr, d, mr);
        tick();
        sa_v = 1'b0; sa_l = 1'b0; sa_dr = 1'b0;
        check("r_lvl", lvl_a, pend_q.size() + stor_q.size());
        check("r_pk", pk_a, mo_pk);
        check("r_mv", ma_v, mo_v);
        if (mo_v) check("r_mdata", {ma_l, ma_data}, mo_b);
        check("r_ovf", ovf_a, m_ovf);
        check("r_drp", drp_a, m_drp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        n_tests = 0; n_fail = 0;
        clk = 1'b0; rst_n = 1'b0;
        sa_v = 0; sa_l = 0; sa_dr = 0; sa_data = 8'h00; ma_r = 0;
        sb_v = 0; sb_l = 0; sb_dr = 0; sb_data = 8'h00; mb_r = 1;

        // Reset state and ready timing
        #12;
        check("rst_rdy", sa_rdy, 0);
        check("rst_mv", ma_v, 0);
        check("rst_lvl", lvl_a, 0);
        check("rst_pk", pk_a, 0);
        rst_n = 1'b1;
        #1;
        check("rel_rdy0", sa_rdy, 0);
        tick();
        check("rel_rdy1", sa_rdy, 1);
        check("rel_rdy1_b", sb_rdy, 1);

        // Three-beat packet into an empty FIFO
        ma_r = 1'b1;
        drive_a(1, 0, 0, 8'h11);
        drive_a(1, 0, 0, 8'h22);
        drive_a(1, 1, 0, 8'h33);
        check("p3_t1_mv", ma_v, 0);
        check("p3_t1_pk", pk_a, 1);
        check("p3_t1_lvl", lvl_a, 3);
        tick();
        check("p3_t2_mv", ma_v, 1);
        check("p3_b0", {ma_l, ma_data}, 9'h011);
        check("p3_t2_lvl", lvl_a, 2);
        tick();
        check("p3_b1", {ma_v, ma_l, ma_data}, 10'h222);
        tick();
        check("p3_b2", {ma_v, ma_l, ma_data}, 10'h333);
        check("p3_b2_pk", pk_a, 1);
        tick();
        check("p3_end_mv", ma_v, 0);
        check("p3_end_pk", pk_a, 0);
        check("p3_end_lvl", lvl_a, 0);

        // Abandoned packet
        drive_a(1, 0, 0, 8'hA1);
        drive_a(1, 0, 0, 8'hA2);
        check("dr_lvl2", lvl_a, 2);
        drive_a(1, 0, 1, 8'hA3);
        check("dr_pulse", drp_a, 1);
        check("dr_rewind", lvl_a, 0);
        drive_a(1, 0, 0, 8'hB1);
        check("dr_pulse_end", drp_a, 0);
        drive_a(1, 1, 0, 8'hB2);
        check("dr_lvl_end", lvl_a, 0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (ma_v) cnt++;
            tick();
        end
        check("dr_nout", cnt, 0);
        check("dr_pk", pk_a, 0);

        // Overflow with drop-on-full, reader stalled
        ma_r = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive_a(1, (i == 9), 0, 8'(8'h40 + i));
            if (ovf_a) cnt++;
        end
        for (int i = 0; i < 10; i++) begin
            drive_a(1, (i == 9), 0, 8'(8'h80 + i));
            if (ovf_a) cnt++;
        end
        tick();
        if (ovf_a) cnt++;
        check("of_pulses", cnt, 1);
        check("of_lvl", lvl_a, 9);
        check("of_pk", pk_a, 1);
        ma_r = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("of_rd", {ma_v, ma_l, ma_data}, {1'b1, (i == 9), 8'(8'h40 + i)});
            tick();
        end
        check("of_end_mv", ma_v, 0);
        check("of_end_pk", pk_a, 0);
        check("of_end_lvl", lvl_a, 0);

        // Oversized packet with backpressure mode
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            check("bp_rdy", sb_rdy, 1);
            drive_b(1, (i == 19), 0, 8'(8'hA0 + i));
            if (ovf_b) cnt++;
            if (mb_v) check("bp_nout", mb_v, 0);
        end
        tick();
        if (ovf_b) cnt++;
        check("bp_pulses", cnt, 1);
        check("bp_lvl", lvl_b, 0);
        drive_b(1, 0, 0, 8'hC0);
        drive_b(1, 1, 0, 8'hC1);
        cnt = 0;
        while (!mb_v && cnt < 10) begin
            tick();
            cnt++;
        end
        check("bp_valid", mb_v, 1);
        check("bp_b0", {mb_l, mb_data}, 9'h0C0);
        tick();
        check("bp_b1", {mb_v, mb_l, mb_data}, 10'h3C1);

        // Reset mid-packet with one packet committed
        ma_r = 1'b0;
        drive_a(1, 0, 0, 8'h61);
        drive_a(1, 1, 0, 8'h62);
        drive_a(1, 0, 0, 8'h71);
        drive_a(1, 0, 0, 8'h72);
        check("mr_pk_pre", pk_a, 1);
        check("mr_mv_pre", ma_v, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_mv", ma_v, 0);
        check("mr_lvl", lvl_a, 0);
        check("mr_pk", pk_a, 0);
        check("mr_flags", {ovf_a, drp_a}, 0);
        check("mr_rdy", sa_rdy, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        check("mr_rel_rdy0", sa_rdy, 0);
        tick();
        check("mr_rel_rdy1", sa_rdy, 1);
        check("mr_rel_lvl", lvl_a, 0);
        ma_r = 1'b1;
        drive_a(1, 0, 0, 8'h51);
        drive_a(1, 0, 0, 8'h52);
        drive_a(1, 1, 0, 8'h53);
        cnt = 0;
        while (!ma_v && cnt < 10) begin
            tick();
            cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            check("mr_rd", {ma_v, ma_l, ma_data}, {1'b1, (i == 2), 8'(8'h51 + i)});
            tick();
        end
        check("mr_end_mv", ma_v, 0);

        // Random packets against the reference model
        pend_q.delete(); stor_q.delete();
        mo_v = 1'b0; m_disc = 1'b0; mo_pk = 0; mo_b = 9'h000;
        for (int p = 0; p < 100; p++) begin
            int len, drop_at;
            len     = int'($urandom_range(1, 6));
            drop_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            for (int b = 0; b < len; b++) begin
                while ($urandom_range(0, 3) == 0) rcyc(0, 0, 0, 8'h00, 1'($urandom_range(0, 1)));
                rcyc(1, (b == len - 1), (b == drop_at), 8'($urandom), 1'($urandom_range(0, 1)));
            end
        end
        cnt = 0;
        while ((stor_q.size() > 0 || mo_v) && cnt < 200) begin
            rcyc(0, 0, 0, 8'h00, 1'b1);
            cnt++;
        end
        check("r_drained", (stor_q.size() > 0 || mo_v), 0);
        check("r_final_lvl", lvl_a, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
